// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand fetch stage.
// Sizes the datapath, register file and the bundle passed to execute.
package operand_fetch_pkg;

  localparam int width       = 32;
  localparam int total_reg   = 32;
  localparam int address_reg = $clog2(total_reg);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [width-1:0]       op1;
    logic [width-1:0]       op2;
    logic [address_reg-1:0] rd;
    logic                   rd_en;
  } operand_bundle_t;

  function automatic logic [width-1:0] sel_operand(
    input logic [address_reg-1:0] rs,
    input logic                   wb_hit,
    input logic [width-1:0]       wb_data,
    input logic [width-1:0]       rf_data
  );
    logic [width-1:0] r;
    r = rf_data;
    if (rs == '0)  r = '0;
    else if (wb_hit) r = wb_data;
    return r;
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy vector: set-wins update, x0 never busy,
// three combinational lookups for rs1, rs2 and rd.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_en,
  input  logic [address_reg-1:0] set_addr,
  input  logic                   clr_en,
  input  logic [address_reg-1:0] clr_addr,
  input  logic [address_reg-1:0] a0,
  input  logic [address_reg-1:0] a1,
  input  logic [address_reg-1:0] a2,
  output logic                   b0,
  output logic                   b1,
  output logic                   b2
);

  logic [total_reg-1:0] busy_q;
  logic [total_reg-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign b0 = busy_q[a0];
  assign b1 = busy_q[a1];
  assign b2 = busy_q[a2];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, bypasses writeback,
// tracks outstanding writes and holds one bundle for execute.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [address_reg-1:0] in_rs1,
  input  logic [address_reg-1:0] in_rs2,
  input  logic [address_reg-1:0] in_rd,
  input  logic                   in_rd_en,
  output logic [address_reg-1:0] rs1,
  output logic [address_reg-1:0] rs2,
  input  logic [width-1:0]       out1,
  input  logic [width-1:0]       out2,
  input  logic                   wb_valid,
  input  logic [address_reg-1:0] wb_rd,
  input  logic [width-1:0]       wb_data,
  output logic                   wenable,
  output logic [address_reg-1:0] rd,
  output logic [width-1:0]       rd_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_op1,
  output logic [width-1:0]       out_op2,
  output logic [address_reg-1:0] out_rd,
  output logic                   out_rd_en,
  output logic [15:0]            stall_cnt
);

  fetch_state_t    state_q, state_d;
  operand_bundle_t bundle_q, bundle_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic busy1, busy2, busy_rd;
  logic hit1, hit2;
  logic haz1, haz2, haz_waw, hazard;
  logic accept, set_en;

  assign rs1   = in_rs1;
  assign rs2   = in_rs2;
  assign rd    = wb_rd;
  assign rd_in = wb_data;
  assign wenable = rst_n && wb_valid && (wb_rd != '0);

  assign hit1 = wb_valid && (wb_rd == in_rs1);
  assign hit2 = wb_valid && (wb_rd == in_rs2);

  assign haz1    = busy1 && (in_rs1 != '0) && !hit1;
  assign haz2    = busy2 && (in_rs2 != '0) && !hit2;
  assign haz_waw = in_rd_en && (in_rd != '0) && busy_rd;
  assign hazard  = haz1 || haz2 || haz_waw;

  assign in_ready = rst_n && !hazard &&
                    (state_q == EMPTY || out_ready);
  assign accept   = in_valid && in_ready;
  assign set_en   = accept && in_rd_en && (in_rd != '0);

  reg_scoreboard u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_addr (in_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_rd),
    .a0       (in_rs1),
    .a1       (in_rs2),
    .a2       (in_rd),
    .b0       (busy1),
    .b1       (busy2),
    .b2       (busy_rd)
  );

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) state_d = FULL;
      end
      FULL: begin
        if (!accept && out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      bundle_d.op1   = sel_operand(in_rs1, hit1, wb_data, out1);
      bundle_d.op2   = sel_operand(in_rs2, hit2, wb_data, out2);
      bundle_d.rd    = in_rd;
      bundle_d.rd_en = in_rd_en;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      bundle_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bundle_q    <= bundle_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_op1   = bundle_q.op1;
  assign out_op2   = bundle_q.op2;
  assign out_rd    = bundle_q.rd;
  assign out_rd_en = bundle_q.rd_en;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus randomized
// traffic against a register-level behavioural model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_en;
  logic [4:0]  rs1, rs2;
  logic [31:0] out1, out2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wenable;
  logic [4:0]  rd;
  logic [31:0] rd_in;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_en;
  logic [15:0] stall_cnt;

  logic [31:0] rf [32];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign out1 = rf[rs1];
  assign out2 = rf[rs2];

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_rd_en(in_rd_en),
    .rs1(rs1), .rs2(rs2), .out1(out1), .out2(out2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wenable(wenable), .rd(rd), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_rd_en(out_rd_en),
    .stall_cnt(stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0;
    in_rd = 0; in_rd_en = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    out_ready = 1;
  endtask

  task automatic req(input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] d, input logic de);
    in_valid = 1; in_rs1 = a; in_rs2 = b;
    in_rd = d; in_rd_en = de;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset;
    idle();
    rst_n = 0;
    req(1, 2, 3, 1);
    wb_valid = 1; wb_rd = 5; wb_data = 32'h55;
    tick(); #1;
    n_cmp++;
    if (in_ready !== 1'b0 || wenable !== 1'b0) begin
      n_err++;
      $display("FAIL reset_comb: in_ready=%b wenable=%b want 0 0",
               in_ready, wenable);
    end
    n_cmp++;
    if (out_valid !== 0 || stall_cnt !== 0 || out_op1 !== 0 ||
        out_op2 !== 0 || out_rd !== 0 || out_rd_en !== 0) begin
      n_err++;
      $display("FAIL reset_regs: v=%b st=%0d op1=%h op2=%h rd=%0d en=%b want zeros",
               out_valid, stall_cnt, out_op1, out_op2, out_rd, out_rd_en);
    end
    rst_n = 1;
    idle();
    #1;
  endtask

  task automatic test_basic;
    do_reset();
    rf[1] = 11; rf[2] = 22;
    req(1, 2, 0, 0);
    #1;
    n_cmp++;
    if (in_ready !== 1 || rs1 !== 1 || rs2 !== 2) begin
      n_err++;
      $display("FAIL basic_ready: in_ready=%b rs1=%0d rs2=%0d want 1 1 2",
               in_ready, rs1, rs2);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1 || out_op1 !== 11 || out_op2 !== 22) begin
      n_err++;
      $display("FAIL basic_ops: v=%b op1=%0d op2=%0d want 1 11 22",
               out_valid, out_op1, out_op2);
    end
    req(1, 2, 1, 1);
    #1;
    n_cmp++;
    if (in_ready !== 1) begin
      n_err++;
      $display("FAIL basic_nobusy: in_ready=%b want 1", in_ready);
    end
    idle();
  endtask

  task automatic test_hazard_bypass;
    do_reset();
    rf[3] = 32'h333;
    req(0, 0, 3, 1);
    tick();
    req(3, 0, 0, 0);
    #1;
    n_cmp++;
    if (in_ready !== 0) begin
      n_err++;
      $display("FAIL raw_stall: in_ready=%b want 0", in_ready);
    end
    tick(); tick();
    n_cmp++;
    if (stall_cnt !== 2 || in_ready !== 0) begin
      n_err++;
      $display("FAIL raw_cnt: stall_cnt=%0d in_ready=%b want 2 0",
               stall_cnt, in_ready);
    end
    wb_valid = 1; wb_rd = 3; wb_data = 100;
    #1;
    n_cmp++;
    if (in_ready !== 1 || wenable !== 1 || rd !== 3 || rd_in !== 100) begin
      n_err++;
      $display("FAIL bypass_comb: rdy=%b we=%b rd=%0d rd_in=%0d want 1 1 3 100",
               in_ready, wenable, rd, rd_in);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1 || out_op1 !== 100 || stall_cnt !== 2) begin
      n_err++;
      $display("FAIL bypass_op: v=%b op1=%0d st=%0d want 1 100 2",
               out_valid, out_op1, stall_cnt);
    end
    wb_valid = 0;
    req(3, 0, 0, 0);
    #1;
    n_cmp++;
    if (in_ready !== 1) begin
      n_err++;
      $display("FAIL busy_cleared: in_ready=%b want 1", in_ready);
    end
    tick();
    n_cmp++;
    if (out_op1 !== 32'h333) begin
      n_err++;
      $display("FAIL rf_read: op1=%h want 333", out_op1);
    end
    idle();
  endtask

  task automatic test_x0;
    do_reset();
    rf[3] = 32'h3a3;
    wb_valid = 1; wb_rd = 0; wb_data = 200;
    #1;
    n_cmp++;
    if (wenable !== 0) begin
      n_err++;
      $display("FAIL x0_wen: wenable=%b want 0", wenable);
    end
    req(0, 3, 0, 0);
    tick();
    n_cmp++;
    if (out_op1 !== 0 || out_op2 !== 32'h3a3) begin
      n_err++;
      $display("FAIL x0_read: op1=%h op2=%h want 0 3a3", out_op1, out_op2);
    end
    idle();
  endtask

  task automatic test_back_to_back;
    do_reset();
    rf[1] = 101; rf[2] = 102; rf[4] = 104; rf[5] = 105;
    req(1, 2, 6, 0);
    tick();
    out_ready = 0;
    req(4, 5, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 0 || out_valid !== 1 || out_op1 !== 101 ||
          out_op2 !== 102 || out_rd !== 6) begin
        n_err++;
        $display("FAIL hold_%0d: rdy=%b v=%b op1=%0d op2=%0d rd=%0d",
                 i, in_ready, out_valid, out_op1, out_op2, out_rd);
      end
      tick();
    end
    out_ready = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1 || stall_cnt !== 5) begin
      n_err++;
      $display("FAIL release: rdy=%b st=%0d want 1 5", in_ready, stall_cnt);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1 || out_op1 !== 104 || out_op2 !== 105) begin
      n_err++;
      $display("FAIL next_bundle: v=%b op1=%0d op2=%0d want 1 104 105",
               out_valid, out_op1, out_op2);
    end
    in_valid = 0;
    tick();
    n_cmp++;
    if (out_valid !== 0) begin
      n_err++;
      $display("FAIL drain: out_valid=%b want 0", out_valid);
    end
    idle();
  endtask

  task automatic test_set_wins;
    do_reset();
    wb_valid = 1; wb_rd = 5; wb_data = 9;
    req(0, 0, 5, 1);
    #1;
    n_cmp++;
    if (in_ready !== 1) begin
      n_err++;
      $display("FAIL setwin_acc: in_ready=%b want 1", in_ready);
    end
    tick();
    wb_valid = 0;
    req(5, 0, 0, 0);
    #1;
    n_cmp++;
    if (in_ready !== 0) begin
      n_err++;
      $display("FAIL setwin_busy: in_ready=%b want 0", in_ready);
    end
    idle();
  endtask

  task automatic test_reset_mid;
    do_reset();
    rf[7] = 32'h777;
    req(0, 0, 7, 1);
    tick();
    out_ready = 0;
    req(7, 0, 0, 0);
    tick(); tick();
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (out_valid !== 0 || stall_cnt !== 0 || in_ready !== 0) begin
      n_err++;
      $display("FAIL rst_mid: v=%b st=%0d rdy=%b want 0 0 0",
               out_valid, stall_cnt, in_ready);
    end
    tick();
    rst_n = 1;
    out_ready = 1;
    #1;
    n_cmp++;
    if (in_ready !== 1) begin
      n_err++;
      $display("FAIL rst_x7: in_ready=%b want 1", in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1 || out_op1 !== 32'h777) begin
      n_err++;
      $display("FAIL rst_x7_op: v=%b op1=%h want 1 777", out_valid, out_op1);
    end
    idle();
  endtask

  task automatic test_random;
    bit          m_busy [32];
    bit          m_full;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_rd;
    bit          m_rd_en;
    int          m_stall;
    bit          h1, h2, hw, exp_rdy, acc;
    do_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_full = 0; m_stall = 0;
    m_op1 = 0; m_op2 = 0; m_rd = 0; m_rd_en = 0;
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(9, 0) < 7);
      in_rs1    = 5'($urandom_range(7, 0));
      in_rs2    = 5'($urandom_range(7, 0));
      in_rd     = 5'($urandom_range(7, 0));
      in_rd_en  = 1'($urandom_range(1, 0));
      wb_valid  = ($urandom_range(9, 0) < 4);
      wb_rd     = 5'($urandom_range(7, 0));
      wb_data   = $urandom;
      out_ready = ($urandom_range(9, 0) < 7);
      #1;
      h1 = in_rs1 != 0 && m_busy[in_rs1] &&
           !(wb_valid && wb_rd == in_rs1);
      h2 = in_rs2 != 0 && m_busy[in_rs2] &&
           !(wb_valid && wb_rd == in_rs2);
      hw = in_rd_en && in_rd != 0 && m_busy[in_rd];
      exp_rdy = !(h1 || h2 || hw) && (!m_full || out_ready);
      n_cmp++;
      if (in_ready !== exp_rdy ||
          wenable !== (wb_valid && wb_rd != 0)) begin
        n_err++;
        $display("FAIL rnd_comb c=%0d: rdy=%b we=%b want %b %b",
                 c, in_ready, wenable, exp_rdy, wb_valid && wb_rd != 0);
      end
      acc = in_valid && exp_rdy;
      if (in_valid && !exp_rdy && m_stall < 65535) m_stall++;
      if (acc) begin
        m_op1 = (in_rs1 == 0) ? 0 :
                (wb_valid && wb_rd == in_rs1) ? wb_data : rf[in_rs1];
        m_op2 = (in_rs2 == 0) ? 0 :
                (wb_valid && wb_rd == in_rs2) ? wb_data : rf[in_rs2];
        m_rd = in_rd; m_rd_en = in_rd_en;
        m_full = 1;
      end else if (out_ready) begin
        m_full = 0;
      end
      if (wb_valid) m_busy[wb_rd] = 0;
      if (acc && in_rd_en && in_rd != 0) m_busy[in_rd] = 1;
      tick();
      n_cmp++;
      if (out_valid !== m_full || stall_cnt !== 16'(m_stall) ||
          (m_full && (out_op1 !== m_op1 || out_op2 !== m_op2 ||
                      out_rd !== m_rd || out_rd_en !== m_rd_en))) begin
        n_err++;
        $display("FAIL rnd_out c=%0d: v=%b st=%0d op1=%h op2=%h rd=%0d en=%b want %b %0d %h %h %0d %b",
                 c, out_valid, stall_cnt, out_op1, out_op2, out_rd,
                 out_rd_en, m_full, m_stall, m_op1, m_op2, m_rd, m_rd_en);
      end
    end
    idle();
  endtask

  initial begin
    foreach (rf[i]) rf[i] = $urandom;
    rf[0] = 32'hdead_beef;
    idle();
    rst_n = 0;
    test_reset();
    test_basic();
    test_hazard_bypass();
    test_x0();
    test_back_to_back();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute operand fetch stage and sole initiator of the processor register file: accepts decoded register specifiers over a valid/ready handshake and drives the register file read addresses. It captures both operands into an output register and forwards execute-stage writebacks to the register-file write port. It keeps a per-register scoreboard that stalls reads of registers with an outstanding write. It also bypasses writeback data that arrives in the same cycle as the read.

## Interface
- `width`, 32, datapath width in bits
- `total_reg`, 32, number of architectural registers (x0 hardwired zero)
- `address_reg`, `$clog2(total_reg)`, register address width
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in 1: decoded instruction present
- `in_ready` out 1: instruction accepted this cycle when `in_valid` is also high
- `in_rs1`, `in_rs2` in `address_reg`: source register specifiers
- `in_rd` in `address_reg`: destination specifier
- `in_rd_en` in 1: instruction will write `in_rd`
- `rs1`, `rs2` out `address_reg`: register-file read addresses, equal to `in_rs1`/`in_rs2` combinationally
- `out1`, `out2` in `width`: register-file read data, same-cycle (asynchronous read)
- `wb_valid` in 1, `wb_rd` in `address_reg`, `wb_data` in `width`: writeback from execute
- `wenable`, `rd`, `rd_in` out: register-file write port, combinational copy of `wb_valid`/`wb_rd`/`wb_data`; `wenable` is forced low when `wb_rd==0`
- `out_valid` out 1, `out_ready` in 1: operand bundle handshake to execute
- `out_op1`, `out_op2` out `width`; `out_rd` out `address_reg`; `out_rd_en` out 1
- `stall_cnt` out 16: saturating count of cycles with `in_valid && !in_ready`

## Operation
- Scoreboard `busy[total_reg]`; `busy[0]` is constant 0.
- A source is hazarded when `busy[rs]` is set, `rs != 0`, and the condition `wb_valid && wb_rd==rs` is false.
- WAW is hazarded when `in_rd_en && in_rd != 0 && busy[in_rd]`.
- `hazard` = rs1 hazard | rs2 hazard | WAW hazard.
- FSM `EMPTY`/`FULL` on the output register.
  - `in_ready = !hazard && (state==EMPTY || out_ready)`.
  - Accept in `EMPTY` moves to `FULL`.
  - Accept in `FULL` with `out_ready` stays `FULL` with the new bundle.
  - No accept in `FULL` with `out_ready` moves to `EMPTY`.
  - No accept with `!out_ready` holds, and the bundle stays stable.
- Operand select, per source:
  - x0 gives 0.
  - If `wb_valid && wb_rd==rs`, select `wb_data` (bypass).
  - Otherwise select `out1`/`out2`.
- On accept with `in_rd_en && in_rd!=0`: set `busy[in_rd]`.
- On `wb_valid`: clear `busy[wb_rd]`. If a set and a clear hit the same register in the same cycle, the set wins.
- Writeback to a non-busy register is legal: it writes the register file and the scoreboard is unchanged.
- `stall_cnt` increments on `in_valid && !in_ready` and saturates at 16'hFFFF.

## Timing
- Reset (async, `rst_n=0`) clears:
  - `state=EMPTY`, `out_valid=0`
  - `out_op1`, `out_op2`, `out_rd`, `out_rd_en` = 0
  - `busy` = all 0, `stall_cnt=0`
- While `rst_n=0`: `in_ready=0`, and `wenable=0` regardless of `wb_valid`.
- Latency: accept in cycle N gives `out_valid` in cycle N+1. Back-to-back throughput is 1 per cycle.
- Scoreboard updates are visible to the hazard check in the cycle after the edge.
- A writeback clearing a hazard unblocks the reader in the same cycle via bypass, with zero-cycle penalty.
- Reset asserted mid-transfer drops the held bundle and all pending busy bits. The first accept is possible in the first cycle with `rst_n=1`.

## Structure
- Package `operand_fetch_pkg`:
  - `width`, `total_reg`, `address_reg` constants
  - `fetch_state_t` enum {EMPTY, FULL}
  - `operand_bundle_t` struct {op1, op2, rd, rd_en}
- Sub-module `reg_scoreboard`: busy vector with set and clear ports, set-wins priority, x0 tied low, and a combinational lookup for three addresses.

## Test plan
- Reset, then accept rs1=1, rs2=2 with `out1=11`, `out2=22`. Required: `out_valid` next cycle with op1=11, op2=22, and `busy` unchanged.
- Accept rd=3 with `rd_en` set, then request rs1=3 with `wb_valid=0`. Required: `in_ready=0` and `stall_cnt` incrementing. Then drive `wb_valid`, `wb_rd=3`, `wb_data=100`. Required: accept the same cycle with op1=100, and `wenable=1`, `rd=3`, `rd_in=100`.
- Writeback `wb_rd=0`, `wb_data=200`. Required: `wenable=0`. Then read rs1=0, rs2=3. Required: op1=0.
- Hold `out_ready=0` with a bundle in `FULL` and `in_valid=1`. Required: `in_ready=0` and the bundle stable for 5 cycles. Then raise `out_ready`. Required: the next bundle follows immediately.
- Accept rd=5 while `wb_valid`, `wb_rd=5` in the same cycle. Required: `busy[5]` stays set, and a later read of x5 stalls.
- Assert `rst_n=0` mid-stall with `busy[7]` set. Required: `out_valid=0`, `stall_cnt=0`, and a read of x7 is accepted in the first post-reset cycle.
